ps2_tx_funcmod: RTL and testbench
=================================

Name: ps2_tx_funcmod

Overview:
- PS/2 host-to-device transmitter. Sends one command byte to a keyboard or mouse, e.g. 8'hF4 (enable) or 8'hED (set LEDs).
- Drives the open-drain PS2_CLK/PS2_DAT pair: inhibit, request-to-send, bit-serial send clocked by the device, then ACK check.
- Sits beside ps2_funcmod on the same PS/2 pins. The top level arbitrates via oBusy: receiver data is ignored while oBusy=1.

Parameters:
- INHIBIT_CYC, 5000, CLOCK cycles PS2_CLK is held low before request-to-send (100 us at 50 MHz).
- TIMEOUT_CYC, 750000, max CLOCK cycles from CLK release to the ACK sample (15 ms at 50 MHz).

Ports:
- CLOCK  in  1  system clock
- RESET  in  1  asynchronous, active-low reset
- PS2_CLK  inout  1  PS/2 clock; module drives only 1'b0 or 1'bz
- PS2_DAT  inout  1  PS/2 data; module drives only 1'b0 or 1'bz
- iCall  in  1  transfer request; caller holds high until oDone
- iData  in  8  command byte; latched in IDLE when iCall=1
- oDone  out  1  one-cycle completion pulse
- oTag  out  2  result, valid from oDone until next start: 00 ACK ok, 01 no ACK, 10 timeout
- oBusy  out  1  high from start until return to IDLE

Behaviour:
- Reset (async, RESET=0): both lines released (z), state IDLE, oDone=0, oTag=00, oBusy=0, all counters 0. Reset mid-transfer releases lines immediately.
- Input sync: PS2_CLK and PS2_DAT pass through 2-FF synchronizers. Falling edge (fe) = sync history 1→0. All decisions use synchronized values.
- Frame: D0..D7 LSB first, odd parity P (XOR of data inverted), stop=1 (line released).
- IDLE: lines z. iCall=1 → latch iData, compute P, oBusy=1 next cycle, go INHIBIT.
- INHIBIT: CLK=0 for INHIBIT_CYC cycles. DAT=0 on the last cycle. Go RTS.
- RTS: release CLK and keep DAT=0. Clear bit counter n=0. Start timeout counter. Go SEND.
- SEND: on each fe, n increments and DAT is updated the same cycle:
  - n=1..8 → D(n-1)
  - n=9 → P
  - n=10 → release DAT (stop bit), go ACK
  - A bit driven 1 means z, never a driven 1.
- ACK: on next fe (11th), sample sync DAT. 0 → tag 00, 1 → tag 01. Go RELWAIT.
- RELWAIT: wait until sync CLK=1 and sync DAT=1, then go DONE.
- Timeout counter: counts every cycle in SEND/ACK/RELWAIT.
  - Reaching TIMEOUT_CYC before DONE → release both lines, tag 10, go DONE.
  - The counter stops in DONE.
- DONE: oDone=1 for exactly one cycle, oTag updated the same cycle. Go WAITLOW.
- WAITLOW: wait for iCall=0, then go IDLE and set oBusy=0. A held iCall never restarts a transfer.
- iData/iCall changes during a transfer are ignored.
- fe arriving in INHIBIT is ignored (the host owns CLK).
- fe in the same cycle the timeout hits: timeout wins.
- Counters are sized by $clog2 of their parameters. No wrap occurs before the terminal compare.

Optional Feature:
- Macro PS2_TX_RESEND_EN.
- Defined: on tag 01 (no ACK), the module automatically retries once from INHIBIT with the same latched byte. The timeout counter is cleared at each RTS.
  - Second NAK → tag 01.
  - ACK on the retry → tag 00.
  - oDone pulses once, after the final attempt only.
- Undefined: no retry. The first NAK reports tag 01.

Test Plan:
- Bench device model generates ~12 kHz clock (40 us half-period) after CLK release and ACKs. iData=8'hF4 → device samples D=0,0,1,0,1,1,1,1, P=0, stop=1, ACK. Expect oTag=00, a single-cycle oDone, and PS2_CLK low for exactly INHIBIT_CYC cycles before release.
- iData=8'hED, device ACKs → P=1 (line z). iData=8'h00 → P=1. Verify all 11 bit levels at each device rising edge.
- Device never drives ACK (DAT stays high at 11th fe) → oTag=01. With PS2_TX_RESEND_EN: two full frames observed, then one oDone with oTag=01.
- Device never clocks after RTS → after TIMEOUT_CYC cycles both lines z, oTag=10, oDone pulse, oBusy drops once iCall=0.
- RESET=0 asserted at n=5 of SEND → PS2_CLK/PS2_DAT z asynchronously, oBusy=0. A new iCall after reset produces a clean frame.
- iCall held high through oDone for 100 cycles → no second INHIBIT. Drop then raise iCall → new transfer starts.

Source files
------------

// File: rtl/ps2_tx_funcmod.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, device-clocked frame, ACK check.
// Optional PS2_TX_RESEND_EN: one automatic retry after a missing ACK.
module ps2_tx_funcmod #(
  parameter int INHIBIT_CYC = 5000,
  parameter int TIMEOUT_CYC = 750000
) (
  input  logic       CLOCK,
  input  logic       RESET,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT,
  input  logic       iCall,
  input  logic [7:0] iData,
  output logic       oDone,
  output logic [1:0] oTag,
  output logic       oBusy
);

`ifdef PS2_TX_RESEND_EN
  localparam bit RESEND = 1'b1;
`else
  localparam bit RESEND = 1'b0;
`endif

  localparam int IW = (INHIBIT_CYC > 1) ? $clog2(INHIBIT_CYC) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INH     = 3'd1;
  localparam logic [2:0] S_RTS     = 3'd2;
  localparam logic [2:0] S_SEND    = 3'd3;
  localparam logic [2:0] S_ACK     = 3'd4;
  localparam logic [2:0] S_REL     = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;
  localparam logic [2:0] S_WAITLOW = 3'd7;

  logic [2:0]    state;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [3:0]    n;
  logic [7:0]    data;
  logic          par;
  logic          dat_low;
  logic [1:0]    res;
  logic          retried;
  logic [1:0]    clk_sync, dat_sync;
  logic          clk_prev;
  logic          fe, inh_last, tmo_hit;

  assign fe       = clk_prev & ~clk_sync[1];
  assign inh_last = (inh_cnt == IW'(INHIBIT_CYC - 1));
  assign tmo_hit  = (tmo_cnt == TW'(TIMEOUT_CYC - 1)) &&
                    (state == S_SEND || state == S_ACK || state == S_REL);

  // Open-drain: only ever pull low or release.
  assign PS2_CLK = (state == S_INH) ? 1'b0 : 1'bz;
  assign PS2_DAT = (dat_low || (state == S_INH && inh_last)) ? 1'b0 : 1'bz;

  assign oDone = (state == S_DONE);
  assign oBusy = (state != S_IDLE);

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], PS2_CLK};
      dat_sync <= {dat_sync[0], PS2_DAT};
      clk_prev <= clk_sync[1];
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state   <= S_IDLE;
      inh_cnt <= '0;
      tmo_cnt <= '0;
      n       <= '0;
      data    <= '0;
      par     <= 1'b0;
      dat_low <= 1'b0;
      res     <= 2'b00;
      retried <= 1'b0;
      oTag    <= 2'b00;
    end else begin
      case (state)
        S_IDLE: if (iCall) begin
          data    <= iData;
          par     <= ~^iData;
          retried <= 1'b0;
          inh_cnt <= '0;
          state   <= S_INH;
        end
        S_INH: if (inh_last) begin
          inh_cnt <= '0;
          dat_low <= 1'b1;
          state   <= S_RTS;
        end else begin
          inh_cnt <= inh_cnt + 1'b1;
        end
        S_RTS: begin
          n       <= '0;
          tmo_cnt <= '0;
          state   <= S_SEND;
        end
        S_SEND, S_ACK, S_REL: begin
          // Timeout takes priority over a coincident clock edge.
          if (tmo_hit) begin
            dat_low <= 1'b0;
            oTag    <= 2'b10;
            state   <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (state == S_SEND) begin
              if (fe) begin
                n <= n + 4'd1;
                if (n < 4'd8)       dat_low <= ~data[n[2:0]];
                else if (n == 4'd8) dat_low <= ~par;
                else begin
                  dat_low <= 1'b0;
                  state   <= S_ACK;
                end
              end
            end else if (state == S_ACK) begin
              if (fe) begin
                res   <= dat_sync[1] ? 2'b01 : 2'b00;
                state <= S_REL;
              end
            end else if (clk_sync[1] && dat_sync[1]) begin
              if (RESEND && res == 2'b01 && !retried) begin
                retried <= 1'b1;
                state   <= S_INH;
              end else begin
                oTag  <= res;
                state <= S_DONE;
              end
            end
          end
        end
        S_DONE:    state <= S_WAITLOW;
        S_WAITLOW: if (!iCall) state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_tx_funcmod.sv
// Bench for ps2_tx_funcmod: behavioural PS/2 device clocks frames out of the host and
// compares them with frames built from the byte by popcount parity.
module tb_ps2_tx_funcmod;
  localparam int INH = 40;
  localparam int TMO = 4000;
  localparam int H   = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       call = 1'b0;
  logic [7:0] data = 8'h00;
  logic       done;
  logic [1:0] tag;
  logic       busy;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  wire        ps2_clk, ps2_dat;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pullup (ps2_clk);
  pullup (ps2_dat);
  assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
  assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;

  ps2_tx_funcmod #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO)) dut (
    .CLOCK(clk), .RESET(rst), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat),
    .iCall(call), .iData(data), .oDone(done), .oTag(tag), .oBusy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Start bit, D0..D7, odd parity, stop bit; index 0 goes out first.
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    int ones = 0;
    logic p;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    p = (ones % 2 == 0);
    return {1'b1, p, b, 1'b0};
  endfunction

  // Device side: measures the inhibit, clocks 11 pulses, samples each bit after the
  // rising edge, optionally pulls DAT low for the ACK.
  task automatic dev_frame(input bit ack, output logic [10:0] bits, output int inh, output bit rts_ok);
    inh = 0; rts_ok = 0; bits = '0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (i == 2) data = ~data;
      if (ps2_clk === 1'b0) inh++;
      else if (ps2_dat === 1'b0) begin rts_ok = 1; break; end
    end
    repeat (5) tick();
    bits[0] = ps2_dat;
    for (int k = 1; k <= 11; k++) begin
      dev_clk_low = 1'b1;
      repeat (H) tick();
      dev_clk_low = 1'b0;
      if (k == 11) begin dev_dat_low = 1'b0; break; end
      tick();
      bits[k] = ps2_dat;
      if (k == 10 && ack) dev_dat_low = 1'b1;
      repeat (H - 1) tick();
    end
  endtask

  task automatic finish_xfer(input string name, input logic [1:0] exp_tag);
    int low, pulses;
    for (int c = 0; c < 1000; c++) begin
      if (done === 1'b1) break;
      tick();
    end
    check({name, "_done_seen"}, 32'(done), 1);
    check({name, "_tag"}, 32'(tag), 32'(exp_tag));
    check({name, "_busy"}, 32'(busy), 1);
    tick();
    check({name, "_done_width"}, 32'(done), 0);
    low = 0; pulses = 0;
    repeat (100) begin
      tick();
      if (ps2_clk === 1'b0) low++;
      if (done === 1'b1) pulses++;
    end
    check({name, "_no_restart"}, 32'(low), 0);
    check({name, "_no_extra_done"}, 32'(pulses), 0);
    check({name, "_busy_held"}, 32'(busy), 1);
    call = 1'b0;
    tick(); tick();
    check({name, "_busy_drop"}, 32'(busy), 0);
    check({name, "_tag_kept"}, 32'(tag), 32'(exp_tag));
  endtask

  task automatic run_xfer(input string name, input logic [7:0] b, input bit ack);
    logic [10:0] bits;
    int inh;
    bit ok;
    data = b; call = 1'b1;
    dev_frame(ack, bits, inh, ok);
    check({name, "_rts"}, 32'(ok), 1);
    check({name, "_inhibit_len"}, 32'(inh), 32'(INH));
    check({name, "_frame"}, 32'(bits), 32'(model_frame(b)));
`ifdef PS2_TX_RESEND_EN
    if (!ack) begin
      dev_frame(ack, bits, inh, ok);
      check({name, "_retry_rts"}, 32'(ok), 1);
      check({name, "_retry_inhibit"}, 32'(inh), 32'(INH));
      check({name, "_retry_frame"}, 32'(bits), 32'(model_frame(b)));
    end
`endif
    finish_xfer(name, ack ? 2'b00 : 2'b01);
  endtask

  task automatic wait_rts(output bit ok);
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (ps2_clk === 1'b1 && ps2_dat === 1'b0) begin ok = 1; break; end
    end
  endtask

  initial begin
    bit ok;
    int cnt;
    repeat (3) tick();
    check("rst_clk", 32'(ps2_clk), 1);
    check("rst_dat", 32'(ps2_dat), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_tag", 32'(tag), 0);
    rst = 1'b1;
    repeat (3) tick();

    run_xfer("f4", 8'hF4, 1);
    run_xfer("ed", 8'hED, 1);
    run_xfer("zero", 8'h00, 1);
    run_xfer("ff", 8'hFF, 1);
    for (int r = 0; r < 3; r++) run_xfer("rand", 8'($urandom), 1);
    run_xfer("nak", 8'($urandom), 0);

    // Device never clocks: timeout path.
    data = 8'($urandom); call = 1'b1;
    wait_rts(ok);
    check("to_rts", 32'(ok), 1);
    cnt = 0;
    for (int c = 0; c < TMO + 200; c++) begin
      tick(); cnt++;
      if (done === 1'b1) break;
    end
    check("to_latency_ok", 32'(cnt >= TMO && cnt <= TMO + 3), 1);
    check("to_clk_rel", 32'(ps2_clk), 1);
    check("to_dat_rel", 32'(ps2_dat), 1);
    finish_xfer("timeout", 2'b10);

    // Reset in the middle of SEND after the fifth falling edge.
    data = 8'h0F; call = 1'b1;
    wait_rts(ok);
    check("mid_rts", 32'(ok), 1);
    repeat (5) tick();
    for (int k = 1; k <= 5; k++) begin
      dev_clk_low = 1'b1;
      repeat (H) tick();
      if (k < 5) begin dev_clk_low = 1'b0; repeat (H) tick(); end
    end
    check("mid_dat_d4", 32'(ps2_dat), 0);
    dev_clk_low = 1'b0;
    #1 rst = 1'b0;
    #1;
    check("mid_rst_clk", 32'(ps2_clk), 1);
    check("mid_rst_dat", 32'(ps2_dat), 1);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_tag", 32'(tag), 0);
    call = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    repeat (3) tick();
    run_xfer("post_rst", 8'($urandom), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "time limit");
  end
endmodule
